// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the default operand width.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - Bin, Bout = borrow out.
module full_subtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through one shared
// full-subtractor cell. The result is published only on entry to DONE.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for start; diff/bout hold the last result
//   S_RUN  | one bit per clock, counter selects the bit (WIDTH cycles)
//   S_DONE | one-cycle done pulse; start here chains straight into S_RUN
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] acc_nxt;
   logic [CW-1:0]    cnt;
   logic             borrow_reg;
   logic             cell_d;
   logic             cell_bout;
   logic             accept;
   logic             last_bit;

   assign accept   = start && (state != S_RUN);
   assign last_bit = (state == S_RUN) && (cnt == LAST_BIT);

   full_subtractor u_fs (
      .A    (a_reg[cnt]),
      .B    (b_reg[cnt]),
      .Bin  (borrow_reg),
      .D    (cell_d),
      .Bout (cell_bout)
   );

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt == LAST_BIT) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = start ? S_RUN : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Partial bits accumulate privately so diff never shows a half result.
   always_comb begin
      acc_nxt      = acc_reg;
      acc_nxt[cnt] = cell_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         acc_reg    <= '0;
         cnt        <= '0;
         borrow_reg <= 1'b0;
         diff       <= '0;
         bout       <= 1'b0;
      end else if (accept) begin
         a_reg      <= a;
         b_reg      <= b;
         borrow_reg <= bin;
         cnt        <= '0;
      end else if (state == S_RUN) begin
         acc_reg    <= acc_nxt;
         borrow_reg <= cell_bout;
         if (last_bit) begin
            diff <= acc_nxt;
            bout <= cell_bout;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 vectors, timing, back-to-back,
// reset abort, plus an exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, bin;
   logic [7:0] a, b;
   logic       busy, done, bout;
   logic [7:0] diff;

   logic       start4, bin4;
   logic [3:0] a4, b4;
   logic       busy4, done4, bout4;
   logic [3:0] diff4;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [7:0] prev_diff;

   serial_sub_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
   );

   serial_sub_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       input logic [7:0] ediff, input logic ebout, input string tag);
      int e0, n, nbusy;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_v; bin = tbin;
      @(posedge clk);
      @(negedge clk);
      e0 = cyc; start = 1'b0;
      check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      check({tag, "_hold"}, {24'd0, diff}, {24'd0, prev_diff});
      n = 0; nbusy = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (busy) nbusy++;
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_lat"}, cyc - e0, 32'd8);
      check({tag, "_nbusy"}, nbusy, 32'd8);
      check({tag, "_diff"}, {24'd0, diff}, {24'd0, ediff});
      check({tag, "_bout"}, {31'd0, bout}, {31'd0, ebout});
      @(negedge clk);
      check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
      prev_diff = ediff;
   endtask

   initial begin
      int e0, n, seen, overlap;
      logic [7:0] oa [3], ob [3], od [3];
      logic       oc [3], obo [3];
      logic [4:0] exp5;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      prev_diff = 8'h00;
      #3;
      check("rst_outs", {22'd0, busy, done, bout, diff}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "r028");
      run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "r029a");
      run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "r029b");
      run8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "r029c");
      run8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "bmax");

      // second start during RUN must be ignored
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
      @(posedge clk); @(negedge clk);
      e0 = cyc; start = 1'b0;
      @(negedge clk); @(negedge clk);
      start = 1'b1; a = 8'h00; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      check("r030_done", {31'd0, done}, 32'd1);
      check("r030_lat", cyc - e0, 32'd8);
      check("r030_diff", {23'd0, bout, diff}, 32'h00F);
      @(negedge clk);
      check("r030_idle", {30'd0, busy, done}, 32'd0);

      // back-to-back with start held high
      oa = '{8'h20, 8'h01, 8'h80}; ob = '{8'h01, 8'h02, 8'h7F}; oc = '{1'b0, 1'b0, 1'b1};
      od = '{8'h1F, 8'hFF, 8'h00}; obo = '{1'b0, 1'b1, 1'b0};
      @(negedge clk);
      start = 1'b1; a = oa[0]; b = ob[0]; bin = oc[0];
      @(posedge clk); @(negedge clk);
      e0 = cyc; overlap = 0;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (busy == done) overlap++;
         end while (!done && n < 40);
         check("r031_done", {31'd0, done}, 32'd1);
         check("r031_gap", cyc - e0, (k == 0) ? 32'd8 : 32'd9);
         check("r031_res", {23'd0, bout, diff}, {23'd0, obo[k], od[k]});
         e0 = cyc;
         if (k < 2) begin a = oa[k+1]; b = ob[k+1]; bin = oc[k+1]; end
         else start = 1'b0;
      end
      check("r031_busy_done", overlap, 32'd0);
      @(negedge clk);
      prev_diff = 8'h00;

      run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "pre_rst");

      // reset mid-operation
      @(negedge clk);
      start = 1'b1; a = 8'h55; b = 8'h11; bin = 1'b0;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("r032_rst", {22'd0, busy, done, bout, diff}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      prev_diff = 8'h00;
      seen = 0;
      repeat (12) begin @(negedge clk); if (done || busy) seen++; end
      check("r032_nodone", seen, 32'd0);
      run8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, "r032_after");

      // exhaustive WIDTH=4 sweep
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               @(negedge clk);
               start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci);
               @(negedge clk);
               start4 = 1'b0;
               n = 0;
               while (!done4 && n < 20) begin @(negedge clk); n++; end
               exp5 = 5'(ai) - 5'(bi) - 5'(ci);
               if (!done4) check("sweep_timeout", {31'd0, done4}, 32'd1);
               check($sformatf("sweep_%0d_%0d_%0d", ai, bi, ci),
                     {27'd0, bout4, diff4}, {27'd0, exp5});
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
